atm_session_ctrl: RTL
=====================

# atm_session_ctrl

Parametrised ATM session controller for the bank-system datapath. It runs one customer session from card insertion through PIN check, language choice, service selection (balance, deposit, withdraw) and confirmation. Unlike the single-width fixed-flow controller, it adds per-session PIN-retry lockout, an inactivity timeout, a global cancel, and a checked balance register with underflow/overflow rejection. It sits between the keypad/card-reader front end and the account store, which supplies the opening balance and receives the closing one.

## Interface
- CARD_W, 8, card number width
- PIN_W, 4, PIN width
- BAL_W, 8, balance width (unsigned)
- AMT_W, 5, transaction amount width (unsigned, AMT_W ≤ BAL_W)
- MAX_TRIES, 3, wrong PINs allowed before lockout (≥1)
- TIMEOUT, 16, idle cycles before forced eject (≥2)

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- card_valid  in  1  card inserted, card_no valid
- card_no  in  CARD_W  card number; 0 = invalid card
- balance_in  in  BAL_W  opening balance from account store
- pin  in  PIN_W  entered PIN, sampled with pin_valid
- correct_pin  in  PIN_W  stored PIN for this card
- pin_valid  in  1  PIN entry strobe
- lang  in  1  language select, sampled with lang_valid
- lang_valid  in  1  language strobe
- service  in  2  0 balance, 1 deposit, 2 withdraw, 3 exit
- service_valid  in  1  service strobe
- amount  in  AMT_W  transaction amount, sampled with amount_valid
- amount_valid  in  1  amount strobe
- confirm  in  1  confirm pending transaction
- another  in  1  1 = another service, 0 = finish; sampled with another_valid
- another_valid  in  1  another-service strobe
- cancel  in  1  abort session
- state_o  out  4  current state
- balance_o  out  BAL_W  working balance
- lang_o  out  1  latched language
- dispense  out  1  one-cycle pulse: withdrawal committed
- deposit_ack  out  1  one-cycle pulse: deposit committed
- show_bal  out  1  one-cycle pulse: balance displayed
- card_eject  out  1  one-cycle pulse: card returned
- locked  out  1  session locked (card retained)
- err_code  out  3  0 none, 1 bad PIN, 2 locked, 3 insufficient, 4 overflow, 5 zero amount, 6 timeout

## Operation
State encodings: IDLE 0000, LANG 0001, PIN 0010, SERVICE 0011, DEPOSIT 0100, ANOTHER 0101, BALANCE 0110, CONFIRM 0111, WITHDRAW 1000, LOCKED 1001, EJECT 1010. Other codes go to IDLE.
- IDLE: card_valid and card_no≠0 → PIN. Load balance_o←balance_in, tries←0, err_code←0. card_no=0 is ignored.
- PIN: on pin_valid, a match goes to LANG. A mismatch sets tries+1 and err_code=1. When tries+1=MAX_TRIES, go to LOCKED with err_code=2.
- LANG: on lang_valid, set lang_o←lang and go to SERVICE.
- SERVICE: on service_valid, 0 → BALANCE, 1 → DEPOSIT, 2 → WITHDRAW, 3 → EJECT.
- BALANCE: one cycle, show_bal=1, then ANOTHER.
- DEPOSIT/WITHDRAW: on amount_valid, latch amt and go to CONFIRM. amount=0 sets err_code=5 and goes to SERVICE.
- CONFIRM: on confirm, apply the amount:
  - withdraw with amt>balance_o: err_code=3, no change.
  - deposit with balance_o+amt>2^BAL_W−1: err_code=4, no change.
  - otherwise update balance_o and pulse dispense or deposit_ack.
  - All three cases go to ANOTHER.
- ANOTHER: on another_valid, 1 → SERVICE, 0 → EJECT.
- EJECT: card_eject=1 for one cycle, then IDLE.
- LOCKED: locked=1, no inputs accepted, held until rst.
- cancel: in PIN, LANG, SERVICE, DEPOSIT, WITHDRAW, CONFIRM or ANOTHER, goes to EJECT with no balance change. It beats any strobe in the same cycle.
- Timeout: an idle counter runs in the same states as cancel. It clears on any accepted strobe or state change. On reaching TIMEOUT it goes to EJECT with err_code=6.
- A strobe in the expiry cycle wins over the timeout.
- err_code holds until the next accepted strobe, which clears it unless that strobe sets a new code.
- Strobes not relevant to the current state are ignored.

## Timing
- Reset values: state_o=IDLE. balance_o, lang_o, all pulses, locked and err_code are 0.
- All outputs registered. A transition lands on the clock edge after the strobe is sampled.
- dispense/deposit_ack assert in the first ANOTHER cycle, the same edge balance_o updates.
- show_bal asserts during the single BALANCE cycle.
- card_eject asserts during the single EJECT cycle.
- rst mid-session aborts immediately: no eject pulse, balance_o cleared.
- Deposit arithmetic uses a BAL_W+1-bit sum. The result is truncated only after the overflow check.

## Test plan
- MAX_TRIES=3, TIMEOUT=16, BAL_W=8. Card 0x5A, balance_in=100, correct PIN: withdraw 30 with confirm → dispense pulse, balance_o=70, state ANOTHER; another=0 → EJECT then IDLE.
- Three wrong PINs → err_code 1,1, then state LOCKED with err_code=2 and locked=1. Strobes ignored until rst; rst → IDLE, locked=0.
- balance_in=250, deposit 10 → err_code=4, balance_o=250. Withdraw 31 after balance set to 20 → err_code=3, balance_o unchanged.
- Enter SERVICE, no strobes for 16 cycles → EJECT with err_code=6. A strobe at cycle 16 keeps the session alive.
- cancel and confirm in the same CONFIRM cycle → EJECT, no dispense, balance unchanged.
- card_valid with card_no=0 → stays IDLE. Amount 0 in DEPOSIT → err_code=5, SERVICE.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card -> PIN -> language -> service -> confirm, with lockout, timeout and cancel.
// Strobe-driven, every transition lands on the edge that samples its strobe; no backpressure, unrelated strobes are dropped.
module atm_session_ctrl #(
   parameter int CARD_W    = 8,
   parameter int PIN_W     = 4,
   parameter int BAL_W     = 8,
   parameter int AMT_W     = 5,
   parameter int MAX_TRIES = 3,
   parameter int TIMEOUT   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              card_valid,
   input  logic [CARD_W-1:0] card_no,
   input  logic [BAL_W-1:0]  balance_in,
   input  logic [PIN_W-1:0]  pin,
   input  logic [PIN_W-1:0]  correct_pin,
   input  logic              pin_valid,
   input  logic              lang,
   input  logic              lang_valid,
   input  logic [1:0]        service,
   input  logic              service_valid,
   input  logic [AMT_W-1:0]  amount,
   input  logic              amount_valid,
   input  logic              confirm,
   input  logic              another,
   input  logic              another_valid,
   input  logic              cancel,
   output logic [3:0]        state_o,
   output logic [BAL_W-1:0]  balance_o,
   output logic              lang_o,
   output logic              dispense,
   output logic              deposit_ack,
   output logic              show_bal,
   output logic              card_eject,
   output logic              locked,
   output logic [2:0]        err_code
);

   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE     = 4'b0000,
      S_LANG     = 4'b0001,
      S_PIN      = 4'b0010,
      S_SERVICE  = 4'b0011,
      S_DEPOSIT  = 4'b0100,
      S_ANOTHER  = 4'b0101,
      S_BALANCE  = 4'b0110,
      S_CONFIRM  = 4'b0111,
      S_WITHDRAW = 4'b1000,
      S_LOCKED   = 4'b1001,
      S_EJECT    = 4'b1010
   } state_t;

   state_t              r_state;
   logic [BAL_W-1:0]    r_bal;
   logic                r_lang;
   logic                r_dispense;
   logic                r_dep_ack;
   logic                r_show;
   logic                r_eject;
   logic                r_locked;
   logic [2:0]          r_err;
   logic [TRY_W-1:0]    r_tries;
   logic [IDLE_W-1:0]   r_idle;
   logic [AMT_W-1:0]    r_amt;
   logic                r_is_wd;

   state_t              w_state_nxt;
   logic [BAL_W-1:0]    w_bal_nxt;
   logic                w_lang_nxt;
   logic [2:0]          w_err_nxt;
   logic [TRY_W-1:0]    w_tries_nxt;
   logic [TRY_W-1:0]    w_tries_inc;
   logic [AMT_W-1:0]    w_amt_nxt;
   logic                w_is_wd_nxt;
   logic                w_dispense_nxt;
   logic                w_dep_ack_nxt;
   logic                w_accept;
   logic                w_timed;
   logic [BAL_W:0]      w_sum;

   // States in which cancel and the inactivity timer are live.
   assign w_timed = r_state inside {S_PIN, S_LANG, S_SERVICE, S_DEPOSIT,
                                    S_WITHDRAW, S_CONFIRM, S_ANOTHER};
   assign w_tries_inc = r_tries + TRY_W'(1);
   assign w_sum       = {1'b0, r_bal} + (BAL_W+1)'(r_amt);

   always_comb begin
      w_state_nxt    = r_state;
      w_bal_nxt      = r_bal;
      w_lang_nxt     = r_lang;
      w_err_nxt      = r_err;
      w_tries_nxt    = r_tries;
      w_amt_nxt      = r_amt;
      w_is_wd_nxt    = r_is_wd;
      w_dispense_nxt = 1'b0;
      w_dep_ack_nxt  = 1'b0;
      w_accept       = 1'b0;

      if (w_timed && cancel) begin
         w_state_nxt = S_EJECT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (card_valid && card_no != '0) begin
                  w_state_nxt = S_PIN;
                  w_bal_nxt   = balance_in;
                  w_tries_nxt = '0;
                  w_err_nxt   = 3'd0;
               end
            end
            S_PIN: begin
               if (pin_valid) begin
                  w_accept = 1'b1;
                  if (pin == correct_pin) begin
                     w_state_nxt = S_LANG;
                     w_err_nxt   = 3'd0;
                  end else begin
                     w_tries_nxt = w_tries_inc;
                     if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
                        w_state_nxt = S_LOCKED;
                        w_err_nxt   = 3'd2;
                     end else begin
                        w_err_nxt   = 3'd1;
                     end
                  end
               end
            end
            S_LANG: begin
               if (lang_valid) begin
                  w_accept    = 1'b1;
                  w_lang_nxt  = lang;
                  w_err_nxt   = 3'd0;
                  w_state_nxt = S_SERVICE;
               end
            end
            S_SERVICE: begin
               if (service_valid) begin
                  w_accept  = 1'b1;
                  w_err_nxt = 3'd0;
                  case (service)
                     2'd0:    w_state_nxt = S_BALANCE;
                     2'd1:    w_state_nxt = S_DEPOSIT;
                     2'd2:    w_state_nxt = S_WITHDRAW;
                     default: w_state_nxt = S_EJECT;
                  endcase
               end
            end
            S_BALANCE: w_state_nxt = S_ANOTHER;
            S_DEPOSIT, S_WITHDRAW: begin
               if (amount_valid) begin
                  w_accept = 1'b1;
                  if (amount == '0) begin
                     w_err_nxt   = 3'd5;
                     w_state_nxt = S_SERVICE;
                  end else begin
                     w_err_nxt   = 3'd0;
                     w_amt_nxt   = amount;
                     w_is_wd_nxt = (r_state == S_WITHDRAW);
                     w_state_nxt = S_CONFIRM;
                  end
               end
            end
            S_CONFIRM: begin
               if (confirm) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_ANOTHER;
                  w_err_nxt   = 3'd0;
                  // Overflow is judged on the carry bit before truncation.
                  if (r_is_wd) begin
                     if (BAL_W'(r_amt) > r_bal) begin
                        w_err_nxt = 3'd3;
                     end else begin
                        w_bal_nxt      = r_bal - BAL_W'(r_amt);
                        w_dispense_nxt = 1'b1;
                     end
                  end else if (w_sum[BAL_W]) begin
                     w_err_nxt = 3'd4;
                  end else begin
                     w_bal_nxt     = w_sum[BAL_W-1:0];
                     w_dep_ack_nxt = 1'b1;
                  end
               end
            end
            S_ANOTHER: begin
               if (another_valid) begin
                  w_accept    = 1'b1;
                  w_err_nxt   = 3'd0;
                  w_state_nxt = another ? S_SERVICE : S_EJECT;
               end
            end
            S_EJECT:  w_state_nxt = S_IDLE;
            S_LOCKED: w_state_nxt = S_LOCKED;
            default:  w_state_nxt = S_IDLE;
         endcase

         if (w_timed && !w_accept && r_idle == IDLE_W'(TIMEOUT - 1)) begin
            w_state_nxt = S_EJECT;
            w_err_nxt   = 3'd6;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bal      <= '0;
         r_lang     <= 1'b0;
         r_dispense <= 1'b0;
         r_dep_ack  <= 1'b0;
         r_show     <= 1'b0;
         r_eject    <= 1'b0;
         r_locked   <= 1'b0;
         r_err      <= 3'd0;
         r_tries    <= '0;
         r_idle     <= '0;
         r_amt      <= '0;
         r_is_wd    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bal      <= w_bal_nxt;
         r_lang     <= w_lang_nxt;
         r_dispense <= w_dispense_nxt;
         r_dep_ack  <= w_dep_ack_nxt;
         r_show     <= (w_state_nxt == S_BALANCE);
         r_eject    <= (w_state_nxt == S_EJECT);
         r_locked   <= (w_state_nxt == S_LOCKED);
         r_err      <= w_err_nxt;
         r_tries    <= w_tries_nxt;
         r_amt      <= w_amt_nxt;
         r_is_wd    <= w_is_wd_nxt;
         if (w_state_nxt != r_state || w_accept) begin
            r_idle <= '0;
         end else if (w_timed) begin
            r_idle <= r_idle + IDLE_W'(1);
         end
      end
   end

   assign state_o     = r_state;
   assign balance_o   = r_bal;
   assign lang_o      = r_lang;
   assign dispense    = r_dispense;
   assign deposit_ack = r_dep_ack;
   assign show_bal    = r_show;
   assign card_eject  = r_eject;
   assign locked      = r_locked;
   assign err_code    = r_err;

endmodule
